// File: rtl/reorder_buffer.sv
// Dual-issue, dual-retire reorder buffer with three completion ports.
// Optional ROB_BYPASS_EN: completions to head/head+1 retire on the capture edge.
module reorder_buffer #(
   parameter int DEPTH  = 16,
   parameter int PREG_W = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alloc_valid_1,
   input  logic                      alloc_valid_2,
   input  logic [1:0]                alloc_type_1,
   input  logic [1:0]                alloc_type_2,
   input  logic [PREG_W-1:0]         alloc_pd_1,
   input  logic [PREG_W-1:0]         alloc_pd_2,
   input  logic [PREG_W-1:0]         alloc_old_pd_1,
   input  logic [PREG_W-1:0]         alloc_old_pd_2,
   output logic                      alloc_ready,
   output logic [$clog2(DEPTH)-1:0]  alloc_idx_1,
   output logic [$clog2(DEPTH)-1:0]  alloc_idx_2,
   input  logic                      cmp_valid_1,
   input  logic                      cmp_valid_2,
   input  logic                      cmp_valid_3,
   input  logic [$clog2(DEPTH)-1:0]  cmp_rob_1,
   input  logic [$clog2(DEPTH)-1:0]  cmp_rob_2,
   input  logic [$clog2(DEPTH)-1:0]  cmp_rob_3,
   input  logic [31:0]               cmp_result_1,
   input  logic [31:0]               cmp_result_2,
   input  logic [31:0]               cmp_result_3,
   output logic                      retire_flag_1,
   output logic                      retire_flag_2,
   output logic [PREG_W-1:0]         retire_pd_1,
   output logic [PREG_W-1:0]         retire_pd_2,
   output logic [31:0]               retire_result_1,
   output logic [31:0]               retire_result_2,
   output logic [1:0]                retire_type_1,
   output logic [1:0]                retire_type_2,
   output logic [PREG_W-1:0]         fp_ind_1,
   output logic [PREG_W-1:0]         fp_ind_2,
   output logic [$clog2(DEPTH):0]    rob_count,
   output logic                      rob_empty,
   output logic                      rob_full
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [IW-1:0]     head, tail, h1, t1;
   logic [CW-1:0]     count, count_next;
   logic [DEPTH-1:0]  e_v, e_comp;
   logic [1:0]        e_type [DEPTH];
   logic [PREG_W-1:0] e_pd   [DEPTH];
   logic [PREG_W-1:0] e_old  [DEPTH];
   logic [31:0]       e_res  [DEPTH];

   logic [DEPTH-1:0]  c_hit;
   logic [31:0]       c_val  [DEPTH];

   logic              acc1, acc2, ret1, ret2;
   logic              done_h, done_h1;
   logic [31:0]       res_h, res_h1;

   assign h1 = head + IW'(1);
   assign t1 = tail + IW'(1);

   assign alloc_ready = (count <= CW'(DEPTH - 2));
   assign alloc_idx_1 = tail;
   assign alloc_idx_2 = t1;
   assign rob_count   = count;
   assign rob_empty   = (count == '0);
   assign rob_full    = (count == CW'(DEPTH));

   assign acc1 = alloc_ready & alloc_valid_1;
   assign acc2 = acc1 & alloc_valid_2;

   // Lowest-numbered port wins when several target the same entry.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         c_hit[i] = 1'b0;
         c_val[i] = '0;
         if (cmp_valid_1 && cmp_rob_1 == IW'(i)) begin
            c_hit[i] = 1'b1;
            c_val[i] = cmp_result_1;
         end else if (cmp_valid_2 && cmp_rob_2 == IW'(i)) begin
            c_hit[i] = 1'b1;
            c_val[i] = cmp_result_2;
         end else if (cmp_valid_3 && cmp_rob_3 == IW'(i)) begin
            c_hit[i] = 1'b1;
            c_val[i] = cmp_result_3;
         end
      end
   end

`ifdef ROB_BYPASS_EN
   assign done_h  = e_v[head] & (e_comp[head] | c_hit[head]);
   assign done_h1 = e_v[h1] & (e_comp[h1] | c_hit[h1]);
   assign res_h   = e_comp[head] ? e_res[head] : c_val[head];
   assign res_h1  = e_comp[h1] ? e_res[h1] : c_val[h1];
`else
   assign done_h  = e_v[head] & e_comp[head];
   assign done_h1 = e_v[h1] & e_comp[h1];
   assign res_h   = e_res[head];
   assign res_h1  = e_res[h1];
`endif

   assign ret1 = done_h;
   assign ret2 = ret1 & done_h1;

   assign count_next = count + CW'(acc1) + CW'(acc2)
                     - CW'(ret1) - CW'(ret2);

   always_ff @(posedge clk) begin
      if (rst) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         e_v             <= '0;
         e_comp          <= '0;
         retire_flag_1   <= 1'b0;
         retire_flag_2   <= 1'b0;
         retire_pd_1     <= '0;
         retire_pd_2     <= '0;
         retire_result_1 <= '0;
         retire_result_2 <= '0;
         retire_type_1   <= '0;
         retire_type_2   <= '0;
         fp_ind_1        <= '0;
         fp_ind_2        <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (c_hit[i] && e_v[i]) e_comp[i] <= 1'b1;
         if (acc1) begin
            e_v[tail]    <= 1'b1;
            e_comp[tail] <= 1'b0;
         end
         if (acc2) begin
            e_v[t1]    <= 1'b1;
            e_comp[t1] <= 1'b0;
         end
         // Clearing last lets retirement win over a late completion.
         if (ret1) begin
            e_v[head]    <= 1'b0;
            e_comp[head] <= 1'b0;
         end
         if (ret2) begin
            e_v[h1]    <= 1'b0;
            e_comp[h1] <= 1'b0;
         end
         head  <= head + IW'(ret1) + IW'(ret2);
         tail  <= tail + IW'(acc1) + IW'(acc2);
         count <= count_next;

         retire_flag_1   <= ret1;
         retire_flag_2   <= ret2;
         retire_pd_1     <= ret1 ? e_pd[head] : '0;
         retire_pd_2     <= ret2 ? e_pd[h1] : '0;
         retire_result_1 <= ret1 ? res_h : '0;
         retire_result_2 <= ret2 ? res_h1 : '0;
         retire_type_1   <= ret1 ? e_type[head] : '0;
         retire_type_2   <= ret2 ? e_type[h1] : '0;
         fp_ind_1 <= (ret1 && e_type[head] != 2'd1) ? e_old[head] : '0;
         fp_ind_2 <= (ret2 && e_type[h1] != 2'd1) ? e_old[h1] : '0;
      end
   end

   // Payload needs no reset: it is only observed behind v/comp.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++)
         if (c_hit[i] && e_v[i]) e_res[i] <= c_val[i];
      if (acc1) begin
         e_type[tail] <= alloc_type_1;
         e_pd[tail]   <= alloc_pd_1;
         e_old[tail]  <= alloc_old_pd_1;
         e_res[tail]  <= '0;
      end
      if (acc2) begin
         e_type[t1] <= alloc_type_2;
         e_pd[t1]   <= alloc_pd_2;
         e_old[t1]  <= alloc_old_pd_2;
         e_res[t1]  <= '0;
      end
   end

endmodule
